// File: rtl/ex_iterative_unit_pkg.sv
// Shared definitions for the iterative execute stage: default widths, funct codes, iteration states.
package ex_iterative_unit_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned REG_ADDR_W_DEF = 5;

  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle,
// owning the HI/LO architectural registers.
module ex_muldiv_iter
  import ex_iterative_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_div,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_q, sh_q, b_q;
  logic [DATA_W-1:0] acc_d, sh_d;
  logic [DATA_W:0]   sum_c, shifted_c;
  logic              last_c;

  assign last_c = (cnt_q == CNT_W'(1));

  // One iteration step; acc holds the upper half (mul) or partial remainder (div).
  always_comb begin
    acc_d     = acc_q;
    sh_d      = sh_q;
    sum_c     = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : '0);
    shifted_c = {acc_q, sh_q[DATA_W-1]};
    case (state_q)
      ST_MUL: {acc_d, sh_d} = {sum_c, sh_q[DATA_W-1:1]};
      ST_DIV: begin
        if (shifted_c >= {1'b0, b_q}) begin
          acc_d = DATA_W'(shifted_c - {1'b0, b_q});
          sh_d  = {sh_q[DATA_W-2:0], 1'b1};
        end else begin
          acc_d = shifted_c[DATA_W-1:0];
          sh_d  = {sh_q[DATA_W-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = is_div ? ST_DIV : ST_MUL;
      ST_MUL,
      ST_DIV:  if (last_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      b_q     <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != ST_IDLE);
      if (state_q == ST_IDLE && start) begin
        cnt_q <= CNT_W'(DATA_W);
        acc_q <= '0;
        sh_q  <= is_div ? op_a : op_b;
        b_q   <= is_div ? op_b : op_a;
      end else if (state_q != ST_IDLE) begin
        acc_q <= acc_d;
        sh_q  <= sh_d;
        if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        if (last_c) begin
          hi <= acc_d;
          lo <= sh_d;
        end
      end
    end
  end

endmodule

// File: rtl/ex_iterative_unit.sv
// Execute stage: single-cycle ALU with registered output slot, plus iterative MULTU/DIVU
// that stalls upstream while running.
module ex_iterative_unit
  import ex_iterative_unit_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned SHAMT_W    = $clog2(DATA_W),
  parameter int unsigned CNT_W      = $clog2(DATA_W) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            funct,
  input  logic [DATA_W-1:0]     operand_1,
  input  logic [DATA_W-1:0]     operand_2,
  input  logic [SHAMT_W-1:0]    shamt,
  input  logic                  write_reg_en_in,
  input  logic [REG_ADDR_W-1:0] write_reg_addr_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     result_out,
  output logic                  write_reg_en_out,
  output logic [REG_ADDR_W-1:0] write_reg_addr_out,
  output logic                  busy
);

  logic              accept_c, is_iter_c, known_c;
  logic [DATA_W-1:0] result_c, hi, lo;

  assign in_ready  = !busy && (!out_valid || out_ready);
  assign accept_c  = in_valid && in_ready;
  assign is_iter_c = (funct == F_MULTU) || (funct == F_DIVU);

  ex_muldiv_iter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept_c && is_iter_c),
    .is_div (funct == F_DIVU),
    .op_a   (operand_1),
    .op_b   (operand_2),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  // Single-cycle ALU; unknown codes yield 0 and suppress write-back.
  always_comb begin
    result_c = '0;
    known_c  = 1'b1;
    case (funct)
      F_OR:    result_c = operand_1 | operand_2;
      F_AND:   result_c = operand_1 & operand_2;
      F_XOR:   result_c = operand_1 ^ operand_2;
      F_NOR:   result_c = ~(operand_1 | operand_2);
      F_ADDU:  result_c = operand_1 + operand_2;
      F_SUBU:  result_c = operand_1 - operand_2;
      F_SLT:   result_c = DATA_W'($signed(operand_1) < $signed(operand_2));
      F_SLTU:  result_c = DATA_W'(operand_1 < operand_2);
      F_SLL:   result_c = operand_2 << shamt;
      F_SRL:   result_c = operand_2 >> shamt;
      F_SRA:   result_c = DATA_W'($signed(operand_2) >>> shamt);
      F_MFHI:  result_c = hi;
      F_MFLO:  result_c = lo;
      F_MULTU,
      F_DIVU:  result_c = '0;
      default: known_c  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid          <= 1'b0;
      result_out         <= '0;
      write_reg_en_out   <= 1'b0;
      write_reg_addr_out <= '0;
    end else if (accept_c && !is_iter_c) begin
      out_valid          <= 1'b1;
      result_out         <= result_c;
      write_reg_en_out   <= write_reg_en_in && known_c;
      write_reg_addr_out <= write_reg_addr_in;
    end else if (out_ready) begin
      out_valid          <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_iterative_unit.sv
// Directed bench for ex_iterative_unit: vector table for single-cycle ops plus
// hand-written MULTU/DIVU, reset-abort and backpressure sequences.
module tb_ex_iterative_unit;
  import ex_iterative_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [5:0]  funct;
  logic [31:0] operand_1, operand_2;
  logic [4:0]  shamt;
  logic        write_reg_en_in;
  logic [4:0]  write_reg_addr_in;
  logic        out_valid, out_ready;
  logic [31:0] result_out;
  logic        write_reg_en_out;
  logic [4:0]  write_reg_addr_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_iterative_unit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .funct              (funct),
    .operand_1          (operand_1),
    .operand_2          (operand_2),
    .shamt              (shamt),
    .write_reg_en_in    (write_reg_en_in),
    .write_reg_addr_in  (write_reg_addr_in),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .result_out         (result_out),
    .write_reg_en_out   (write_reg_en_out),
    .write_reg_addr_out (write_reg_addr_out),
    .busy               (busy)
  );

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [4:0]  addr;
    logic [31:0] exp_res;
    logic        exp_en;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] sh, input logic [4:0] addr,
                              input logic [31:0] exp_res, input logic exp_en);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.sh = sh; v.addr = addr; v.exp_res = exp_res; v.exp_en = exp_en;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [4:0] addr);
    funct = f; operand_1 = a; operand_2 = b; shamt = sh;
    write_reg_en_in = 1'b1; write_reg_addr_in = addr; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, " idle timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic read_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(F_MFHI, 32'd0, 32'd0, 5'd0, 5'd9);
    check({name, " MFHI"}, result_out, exp_hi);
    issue(F_MFLO, 32'd0, 32'd0, 5'd0, 5'd10);
    check({name, " MFLO"}, result_out, exp_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    funct = '0; operand_1 = '0; operand_2 = '0; shamt = '0;
    write_reg_en_in = 1'b0; write_reg_addr_in = '0;

    vecs.push_back(mk(F_MFHI,  32'h0,        32'h0,        5'd0,  5'd1,  32'h0,        1'b1));
    vecs.push_back(mk(F_MFLO,  32'h0,        32'h0,        5'd0,  5'd2,  32'h0,        1'b1));
    vecs.push_back(mk(F_ADDU,  32'hFFFFFFFF, 32'h00000002, 5'd0,  5'd5,  32'h00000001, 1'b1));
    vecs.push_back(mk(F_SUBU,  32'd3,        32'd5,        5'd0,  5'd6,  32'hFFFFFFFE, 1'b1));
    vecs.push_back(mk(F_SLT,   32'hFFFFFFFF, 32'h00000001, 5'd0,  5'd7,  32'h1,        1'b1));
    vecs.push_back(mk(F_SLTU,  32'hFFFFFFFF, 32'h00000001, 5'd0,  5'd8,  32'h0,        1'b1));
    vecs.push_back(mk(F_SRA,   32'h0,        32'h80000000, 5'd4,  5'd9,  32'hF8000000, 1'b1));
    vecs.push_back(mk(F_SRL,   32'h0,        32'h80000000, 5'd31, 5'd10, 32'h00000001, 1'b1));
    vecs.push_back(mk(F_SLL,   32'h0,        32'h00000001, 5'd31, 5'd11, 32'h80000000, 1'b1));
    vecs.push_back(mk(F_OR,    32'hF0F0F0F0, 32'h0F0F0000, 5'd0,  5'd12, 32'hFFFFF0F0, 1'b1));
    vecs.push_back(mk(F_AND,   32'hFF00FF00, 32'h0FF00FF0, 5'd0,  5'd13, 32'h0F000F00, 1'b1));
    vecs.push_back(mk(F_XOR,   32'hAAAA5555, 32'hFFFF0000, 5'd0,  5'd14, 32'h55555555, 1'b1));
    vecs.push_back(mk(F_NOR,   32'h00000000, 32'h00000000, 5'd0,  5'd15, 32'hFFFFFFFF, 1'b1));
    vecs.push_back(mk(6'b111111, 32'h12345678, 32'h1,      5'd0,  5'd16, 32'h0,        1'b0));

    repeat (2) @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset result", result_out, 32'd0);
    check("reset wr_en", 32'(write_reg_en_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) begin
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].addr);
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d result", i), result_out, vecs[i].exp_res);
      check($sformatf("vec%0d wr_en", i), 32'(write_reg_en_out), 32'(vecs[i].exp_en));
      check($sformatf("vec%0d wr_addr", i), 32'(write_reg_addr_out), 32'(vecs[i].addr));
    end

    // MULTU: stall length and full 64-bit product
    issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 5'd3);
    check("multu no entry", 32'(out_valid), 32'd0);
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check("multu stall cycles", 32'(cyc), 32'd32);
    read_hilo("multu", 32'hFFFFFFFE, 32'h00000001);

    issue(F_DIVU, 32'd100, 32'd7, 5'd0, 5'd3);
    check("divu no entry", 32'(out_valid), 32'd0);
    check("divu busy", 32'(busy), 32'd1);
    wait_idle("divu");
    read_hilo("divu 100/7", 32'd2, 32'd14);

    issue(F_DIVU, 32'd5, 32'd0, 5'd0, 5'd3);
    wait_idle("divu0");
    read_hilo("divu 5/0", 32'd5, 32'hFFFFFFFF);

    // Reset five cycles into a MULTU must discard it and clear HI/LO
    issue(F_MULTU, 32'h12345678, 32'h9ABCDEF0, 5'd0, 5'd3);
    repeat (5) @(negedge clk);
    check("mid-mul busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-mul reset busy", 32'(busy), 32'd0);
    check("mid-mul reset out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid-mul in_ready", 32'(in_ready), 32'd1);
    read_hilo("post-reset", 32'd0, 32'd0);

    // Backpressure: entry holds, then drain and accept in one edge
    out_ready = 1'b1;
    issue(F_ADDU, 32'd1, 32'd1, 5'd0, 5'd3);
    out_ready = 1'b0;
    funct = F_XOR; operand_1 = 32'h12; operand_2 = 32'h34; shamt = '0;
    write_reg_en_in = 1'b1; write_reg_addr_in = 5'd7; in_valid = 1'b1;
    #1;
    check("bp in_ready low", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d result", k), result_out, 32'd2);
      check($sformatf("bp%0d addr", k), 32'(write_reg_addr_out), 32'd3);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp next out_valid", 32'(out_valid), 32'd1);
    check("bp next result", result_out, 32'h26);
    check("bp next addr", 32'(write_reg_addr_out), 32'd7);
    @(negedge clk);
    check("bp drained", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
